// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller and its scoreboard.
package fpu_issue_ctrl_pkg;

    typedef logic Signal;
    localparam Signal ENABLE  = 1'b1;
    localparam Signal DISABLE = 1'b0;

    localparam int FP_REG_W    = 5;
    localparam int NUM_FP_REGS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } fpu_issue_state_e;

endpackage

// File: rtl/fp_scoreboard.sv
// Pending-destination scoreboard for FP registers: one set port, one clear
// port and three combinational query ports (fs, ft, fd).
module fp_scoreboard
    import fpu_issue_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en_i,
    input  logic [FP_REG_W-1:0] set_idx_i,
    input  logic                clr_en_i,
    input  logic [FP_REG_W-1:0] clr_idx_i,
    input  logic [FP_REG_W-1:0] fs_idx_i,
    input  logic [FP_REG_W-1:0] ft_idx_i,
    input  logic [FP_REG_W-1:0] fd_idx_i,
    output logic                fs_pend_o,
    output logic                ft_pend_o,
    output logic                fd_pend_o
);

    logic [NUM_FP_REGS-1:0] pending_q, pending_d;

    // Next pending vector; set and clear never target the same bit in one cycle.
    always_comb begin
        pending_d = pending_q;
        if (set_en_i) pending_d[set_idx_i] = ENABLE;
        if (clr_en_i) pending_d[clr_idx_i] = DISABLE;
    end

    // Pending vector register.
    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign fs_pend_o = pending_q[fs_idx_i];
    assign ft_pend_o = pending_q[ft_idx_i];
    assign fd_pend_o = pending_q[fd_idx_i];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer for the multi-cycle ADD.S unit: hazard stall, start pulse,
// timeout abort and FP write-port arbitration (LWC1 writeback wins).
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic                id_flush,
    input  logic                id_fpu_op,
    input  logic                id_fp_load,
    input  logic                id_fp_store,
    input  logic [FP_REG_W-1:0] id_fs,
    input  logic [FP_REG_W-1:0] id_ft,
    input  logic [FP_REG_W-1:0] id_fd,
    input  logic                mem_fpu_write,
    input  logic                fpu_done,
    output logic                stall,
    output logic                fpu_start,
    output logic [FP_REG_W-1:0] fpu_dst,
    output logic                wb_fpu_write,
    output logic [FP_REG_W-1:0] wb_fpu_dst,
    output logic                busy,
    output logic                timeout_err
);

    fpu_issue_state_e    state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FP_REG_W-1:0] dst_q, dst_d;
    logic                terr_q, terr_d;

    logic fs_pend, ft_pend, fd_pend;
    logic set_en, clr_en;
    logic raw, waw, accept;

    fp_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en_i  (set_en),
        .set_idx_i (id_fd),
        .clr_en_i  (clr_en),
        .clr_idx_i (dst_q),
        .fs_idx_i  (id_fs),
        .ft_idx_i  (id_ft),
        .fd_idx_i  (id_fd),
        .fs_pend_o (fs_pend),
        .ft_pend_o (ft_pend),
        .fd_pend_o (fd_pend)
    );

    // Hazard detection and the decode handshake.
    always_comb begin
        raw    = (id_fpu_op & (fs_pend | ft_pend)) | (id_fp_store & ft_pend);
        waw    = (id_fpu_op & fd_pend) | (id_fp_load & ft_pend);
        accept = id_valid & ~id_flush & id_fpu_op & (state_q == IDLE) & ~raw & ~waw;
        stall  = ~reset & id_valid & ~id_flush
               & (raw | waw | (id_fpu_op & (state_q != IDLE)));
    end

    // Next-state logic and scoreboard updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        terr_d  = terr_q;
        set_en  = DISABLE;
        clr_en  = DISABLE;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dst_d   = id_fd;
                    set_en  = ENABLE;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (fpu_done) begin
                    state_d = WB;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandon the op: release its destination, no writeback.
                    clr_en  = ENABLE;
                    terr_d  = ENABLE;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                // LWC1 owns the write port whenever it wants it.
                if (!mem_fpu_write) begin
                    clr_en  = ENABLE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
            terr_q  <= terr_d;
        end
    end

    assign fpu_start    = ~reset & (state_q == ISSUE);
    assign wb_fpu_write = ~reset & (state_q == WB) & ~mem_fpu_write;
    assign busy         = ~reset & (state_q != IDLE);
    assign fpu_dst      = dst_q;
    assign wb_fpu_dst   = dst_q;
    assign timeout_err  = terr_q;

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Sequences the multi-cycle FPU adder (ADD.S) behind the decode stage.
- Accepts ADD.S issue requests from decode, then pulses the FPU start.
- Tracks pending FP destination registers in a 32-entry scoreboard and stalls decode on FP RAW/WAW hazards or while the FPU is busy.
- Arbitrates the single FP register-file write port between the FPU result and LWC1 writeback; LWC1 has priority.

Parameters:
TIMEOUT, 16, max cycles in BUSY waiting for fpu_done before abort (>=2)
CNT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  decode holds a valid instruction
id_flush  in  1  decode instruction is being squashed (branch/jump taken)
id_fpu_op  in  1  decoded ADD.S (DX_ctrl fpu.start)
id_fp_load  in  1  decoded LWC1 (writes id_ft)
id_fp_store  in  1  decoded SWC1 (reads id_ft)
id_fs  in  5  FP source register fs
id_ft  in  5  FP source/destination register ft
id_fd  in  5  FP destination register fd (ADD.S)
mem_fpu_write  in  1  LWC1 writeback uses the FP write port this cycle
fpu_done  in  1  FPU result valid (single-cycle pulse)
stall  out  1  hold decode/fetch, inject bubble into DX
fpu_start  out  1  one-cycle start pulse to the FPU
fpu_dst  out  5  latched destination of the in-flight ADD.S
wb_fpu_write  out  1  write FPU result to the FP register file this cycle
wb_fpu_dst  out  5  FP register written when wb_fpu_write=1
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on TIMEOUT abort, cleared only by reset

Behaviour:
- States: IDLE, ISSUE, BUSY, WB. Registered state; all outputs except stall are registered or decoded from registered state.
- Reset: state=IDLE, pending=32'b0, counter=0, fpu_dst=0, timeout_err=0.
  - fpu_start, wb_fpu_write, busy and stall are 0 during reset.
  - Reset mid-operation abandons the in-flight op; no writeback is issued.
- Hazard (combinational):
  - raw = (id_fpu_op & (pending[id_fs] | pending[id_ft])) | (id_fp_store & pending[id_ft]).
  - waw = (id_fpu_op & pending[id_fd]) | (id_fp_load & pending[id_ft]).
- stall = id_valid & ~id_flush & (raw | waw | (id_fpu_op & state!=IDLE)).
- accept = id_valid & ~id_flush & id_fpu_op & state==IDLE & ~raw & ~waw.
- IDLE: on accept, latch fpu_dst=id_fd, set pending[id_fd], go to ISSUE.
- ISSUE: fpu_start=1 for exactly one cycle, then go to BUSY with counter=0.
- BUSY:
  - fpu_done=1 -> go to WB.
  - Otherwise counter++.
  - counter==TIMEOUT-1 without done: clear pending[fpu_dst], set timeout_err, go to IDLE, no writeback.
- WB:
  - If mem_fpu_write=0: wb_fpu_write=1, wb_fpu_dst=fpu_dst, clear pending[fpu_dst], go to IDLE.
  - If mem_fpu_write=1: stay in WB with wb_fpu_write=0. Hold indefinitely; LWC1 always wins the port.
- fpu_done is sampled only in BUSY; a pulse in IDLE, ISSUE or WB is ignored.
- Latency: accept at cycle N -> fpu_start at N+1 -> earliest fpu_done at N+2 -> wb_fpu_write at N+3.
  - The dependent instruction is released (stall=0) in the cycle after the write, N+4.
- Clear and set of the same pending bit never coincide, because accept is only possible in IDLE.
- id_flush suppresses both accept and stall for that cycle.

Decomposition:
- Shared package (definitions): fpu_issue_state_e {IDLE, ISSUE, BUSY, WB}, FP_REG_W=5, NUM_FP_REGS=32. Reuse the existing Signal/ENABLE/DISABLE definitions.
- Sub-module fp_scoreboard: 32-bit pending vector.
  - Inputs: set_en/set_idx, clr_en/clr_idx.
  - Three combinational read ports: query fs, ft, fd.
  - Synchronous reset.

Test Plan:
- Basic: ADD.S f3=f1+f2 accepted at cycle 10, fpu_done at 13 -> fpu_start only at 11; wb_fpu_write=1, wb_fpu_dst=3 at 14; pending[3]=0 at 15.
- RAW: ADD.S f3 in flight, decode presents SWC1 reading f3 -> stall=1 until the cycle after the f3 writeback; an ADD.S reading f5 also stalls (structural).
- Port conflict: FPU in WB while mem_fpu_write=1 for 3 cycles -> wb_fpu_write=0 for those cycles, =1 on the 4th with dst unchanged.
- Timeout: TIMEOUT=16, fpu_done never asserted -> after 16 BUSY cycles return to IDLE; pending cleared, timeout_err=1 and sticky; no wb_fpu_write.
- Flush/WAW: LWC1 to f7 while f7 pending -> stall=1. The same instruction with id_flush=1 -> stall=0 and no scoreboard change.
- Reset mid-BUSY: assert reset for 1 cycle -> state=IDLE, pending=0, busy=0. A later fpu_done is ignored and no writeback occurs.
